// File: rtl/sio_dmu_pkg.sv
// Shared constants, FSM encoding and parity helper for the SIU-to-DMU outbound scheduler.
package sio_dmu_pkg;

  localparam int SIO_DMU_BEATS  = 4;
  localparam int SIO_DMU_DATA_W = 128;
  localparam int SIO_DMU_PAR_W  = SIO_DMU_DATA_W / 16;

  typedef enum logic [1:0] {IDLE, HDR, DATA} sched_state_e;

  // Even parity over each 16-bit lane of a bus word.
  function automatic logic [SIO_DMU_PAR_W-1:0] calc_parity(input logic [SIO_DMU_DATA_W-1:0] d);
    logic [SIO_DMU_PAR_W-1:0] p;
    p = '0;
    for (int i = 0; i < SIO_DMU_PAR_W; i++) p[i] = ^d[16*i +: 16];
    return p;
  endfunction

endpackage

// File: rtl/sio_dmu_out_sched_if.sv
// SIU-to-DMU outbound bus: header/payload word, parity and the returning credit pulse.
interface sio_dmu_out_sched_if;
  import sio_dmu_pkg::*;

  logic                      sio_dmu_hdr_vld;
  logic                      sio_dmu_datareq;
  logic [SIO_DMU_DATA_W-1:0] sio_dmu_data;
  logic [SIO_DMU_PAR_W-1:0]  sio_dmu_parity;
  logic                      dmu_sio_credit;

  modport master (
    output sio_dmu_hdr_vld, sio_dmu_datareq, sio_dmu_data, sio_dmu_parity,
    input  dmu_sio_credit
  );

  modport slave (
    input  sio_dmu_hdr_vld, sio_dmu_datareq, sio_dmu_data, sio_dmu_parity,
    output dmu_sio_credit
  );
endinterface

// File: rtl/sio_dmu_rr_arb.sv
// Round-robin arbiter: search starts at the source after the last advanced winner.
module sio_dmu_rr_arb #(
  parameter int NUM_REQ = 2
) (
  input  logic                       iol2clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       adv,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = IW + 1;

  logic [IW-1:0] ptr;
  logic [CW-1:0] cand;

  // Descending scan so the candidate closest to ptr is the last (winning) write.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + CW'(k);
      if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
      if (req[cand[IW-1:0]]) begin
        gnt                = '0;
        gnt[cand[IW-1:0]]  = 1'b1;
        gnt_idx            = cand[IW-1:0];
      end
    end
  end

  always_ff @(posedge iol2clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (adv) begin
      ptr <= (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/sio_dmu_out_sched.sv
// Credit-gated round-robin scheduler sequencing header + 4-beat payload onto the sio_dmu bus.
// Define SIO_DMU_PARITY_EN to generate per-16-bit even parity; otherwise parity is tied to 0.
module sio_dmu_out_sched
  import sio_dmu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int CREDITS = 4
) (
  input  logic                              iol2clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                src_vld,
  input  logic [NUM_REQ-1:0]                src_has_data,
  input  logic [NUM_REQ*SIO_DMU_DATA_W-1:0] src_hdr,
  input  logic [NUM_REQ*SIO_DMU_DATA_W-1:0] src_data,
  output logic [NUM_REQ-1:0]                src_hdr_ack,
  output logic [NUM_REQ-1:0]                src_beat_rd,
  output logic                              cred_ovf,
  sio_dmu_out_sched_if.master               dmu
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = 4;
  localparam logic [CW-1:0] CRED_MAX  = CW'(CREDITS);
  localparam logic [1:0]    LAST_BEAT = 2'(SIO_DMU_BEATS - 1);

  sched_state_e              state, state_nxt;
  logic [1:0]                beat_cnt, beat_cnt_nxt;
  logic [IW-1:0]             win_idx;
  logic                      win_data;
  logic [CW-1:0]             cred_cnt;
  logic [NUM_REQ-1:0]        arb_gnt;
  logic [IW-1:0]             arb_idx;
  logic                      bus_free, issue, beat_take;
  logic [SIO_DMU_DATA_W-1:0] data_nxt;
  logic [SIO_DMU_DATA_W-1:0] hdr_a [NUM_REQ];
  logic [SIO_DMU_DATA_W-1:0] dat_a [NUM_REQ];
  logic                      hdr_vld_p1, datareq_p1;
  logic [SIO_DMU_DATA_W-1:0] data_p1;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign hdr_a[gi] = src_hdr[gi*SIO_DMU_DATA_W +: SIO_DMU_DATA_W];
    assign dat_a[gi] = src_data[gi*SIO_DMU_DATA_W +: SIO_DMU_DATA_W];
  end

  sio_dmu_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .iol2clk (iol2clk),
    .rst     (rst),
    .req     (src_vld),
    .adv     (issue),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  // Pulses are suppressed during reset so an abandoned packet sees no further reads.
  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    bus_free     = 1'b0;
    beat_take    = 1'b0;
    case (state)
      IDLE: bus_free = 1'b1;
      HDR: begin
        if (win_data) begin
          beat_take    = 1'b1;
          beat_cnt_nxt = 2'd0;
          state_nxt    = DATA;
        end else begin
          bus_free = 1'b1;
        end
      end
      DATA: begin
        if (beat_cnt == LAST_BEAT) begin
          bus_free = 1'b1;
        end else begin
          beat_take    = 1'b1;
          beat_cnt_nxt = beat_cnt + 2'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    issue     = !rst && bus_free && (|src_vld) && (cred_cnt != '0);
    beat_take = beat_take && !rst;
    if (bus_free) state_nxt = issue ? HDR : IDLE;
  end

  assign src_hdr_ack = issue ? arb_gnt : '0;
  assign src_beat_rd = beat_take ? (NUM_REQ'(1) << win_idx) : '0;
  assign data_nxt    = issue ? hdr_a[arb_idx] : (beat_take ? dat_a[win_idx] : '0);

  always_ff @(posedge iol2clk) begin
    if (rst) begin
      state    <= IDLE;
      beat_cnt <= 2'd0;
      win_idx  <= '0;
      win_data <= 1'b0;
      cred_cnt <= CRED_MAX;
      cred_ovf <= 1'b0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_cnt_nxt;
      if (issue) begin
        win_idx  <= arb_idx;
        win_data <= src_has_data[arb_idx];
      end
      if (issue && !dmu.dmu_sio_credit) begin
        cred_cnt <= cred_cnt - 1'b1;
      end else if (!issue && dmu.dmu_sio_credit) begin
        if (cred_cnt == CRED_MAX) cred_ovf <= 1'b1;
        else                      cred_cnt <= cred_cnt + 1'b1;
      end
    end
  end

  // ---- p1: registered bus word ----
  always_ff @(posedge iol2clk) begin
    if (rst) begin
      hdr_vld_p1 <= 1'b0;
      datareq_p1 <= 1'b0;
      data_p1    <= '0;
    end else begin
      hdr_vld_p1 <= issue;
      datareq_p1 <= issue && src_has_data[arb_idx];
      data_p1    <= data_nxt;
    end
  end

  assign dmu.sio_dmu_hdr_vld = hdr_vld_p1;
  assign dmu.sio_dmu_datareq = datareq_p1;
  assign dmu.sio_dmu_data    = data_p1;

`ifdef SIO_DMU_PARITY_EN
  logic [SIO_DMU_PAR_W-1:0] parity_p1;

  always_ff @(posedge iol2clk) begin
    if (rst) parity_p1 <= '0;
    else     parity_p1 <= calc_parity(data_nxt);
  end

  assign dmu.sio_dmu_parity = parity_p1;
`else
  assign dmu.sio_dmu_parity = '0;
`endif

endmodule

// File: doc/sio_dmu_out_sched.md
# sio_dmu_out_sched

Outbound scheduler for the SIU-to-DMU response path in the iol2clk domain. Arbitrates round-robin among NUM_REQ response sources, each presenting one packet: a 128-bit header plus an optional 64-byte payload. Sequences the shared sio_dmu_* bus as one header cycle followed by four 128-bit payload beats. Gates issue on a DMU receive-buffer credit count.

## Interface
Parameters:
- NUM_REQ, 2: number of response sources (2..4).
- CREDITS, 4: DMU receive-buffer credits available after reset (1..15).

Ports:
- iol2clk  in  1  clock; the only clock.
- rst  in  1  reset; synchronous, active-high.
- src_vld  in  NUM_REQ  source i has a packet at its head.
- src_has_data  in  NUM_REQ  source i's head packet carries a 64-byte payload.
- src_hdr  in  NUM_REQ*128  head header of source i (slice i = bits 128i+127:128i).
- src_data  in  NUM_REQ*128  current payload beat of source i (show-ahead).
- src_hdr_ack  out  NUM_REQ  one-cycle pulse: header of source i consumed.
- src_beat_rd  out  NUM_REQ  pulse: payload beat of source i consumed; source advances next cycle.
- dmu_sio_credit  in  1  one-cycle pulse returning one credit.
- sio_dmu_hdr_vld  out  1  header cycle.
- sio_dmu_datareq  out  1  asserted with hdr_vld when a 4-beat payload follows.
- sio_dmu_data  out  128  header or payload beat.
- sio_dmu_parity  out  8  per-16-bit parity of sio_dmu_data.
- cred_ovf  out  1  sticky: credit returned while counter at CREDITS.

## Operation
- State machine with three states: IDLE, HDR, DATA. DATA uses a 2-bit beat counter (0..3).
- Issue condition: at least one src_vld, credit count > 0, and the bus free. The bus is free in IDLE, in HDR for a header-only packet, or in DATA at beat 3.
- On issue:
  - Round-robin arbiter picks the winner w, starting the search at the source after the last winner.
  - Pulse src_hdr_ack[w].
  - Register src_hdr[w] onto sio_dmu_data next cycle, with hdr_vld=1 and datareq=src_has_data[w].
  - Decrement credit count.
  - Go to HDR.
- HDR with data:
  - Pulse src_beat_rd[w] and capture src_data[w] for output next cycle.
  - Go to DATA beat 0.
- DATA beat n:
  - Output beat n; for n<3, pulse src_beat_rd[w] and capture the next beat.
  - After beat 3, go to HDR if the issue condition holds, else IDLE.
- Header-only HDR: go to HDR if the issue condition holds, else IDLE.
- Header passes through unmodified: response type in bits 127:122, tag in bits 79:64, bits 39:0 unused for responses.
- Credit counter:
  - Range 0..CREDITS.
  - Issue and dmu_sio_credit in the same cycle leave it unchanged.
  - A return at CREDITS without an issue is dropped and sets cred_ovf.
- Winner index w is held from issue through the last beat. src_vld changes of other sources have no effect mid-packet.
- Outside the hdr_vld and payload cycles, sio_dmu_data and sio_dmu_parity are 0.

## Timing
- Reset values: all outputs 0, credit count = CREDITS, round-robin pointer = source 0, state IDLE. Reset mid-packet abandons the packet with no further beat_rd pulses.
- Latency: src_hdr_ack at cycle T → hdr_vld at T+1. Payload beats appear at T+2..T+5. src_beat_rd pulses at T+1..T+4.
- Back-to-back: a data packet occupies 5 bus cycles. The next header may appear at T+6 with zero bubble. Consecutive header-only packets issue every cycle.
- With credit count 0, the bus stalls in IDLE. A returned credit at cycle C allows src_hdr_ack at C+1.

## Configuration
- SIO_DMU_PARITY_EN defined: sio_dmu_parity[i] = XOR of sio_dmu_data[16i+15:16i], registered with the data (even parity).
- SIO_DMU_PARITY_EN undefined: parity logic compiled out and sio_dmu_parity tied to 8'h00.

## Structure
- Package sio_dmu_pkg holds:
  - SIO_DMU_BEATS=4 and data/parity width constants.
  - State enum {IDLE, HDR, DATA}.
  - Parity function.
- Sub-module sio_dmu_rr_arb: NUM_REQ round-robin arbiter with request, advance and one-hot grant.
- Credit counter and FSM live in sio_dmu_out_sched.

## Test plan
- Single data packet from source 0, header 128'h0400…_ABCD_… → hdr_vld with datareq=1 and data bits 79:64 = 16'hABCD, then beats D0..D3 on the next 4 cycles; parity matches per 16-bit XOR.
- Sources 0 and 1 both valid continuously with data packets → grants alternate 0,1,0,1; headers at cycles 1,6,11,16 with no bubbles.
- CREDITS=2, no credit returns, 3 packets queued → exactly 2 issue; the third issues the cycle after a dmu_sio_credit pulse.
- Credit return at the same edge as issue with count=1 → count stays 1. Extra return at count=CREDITS → cred_ovf=1 and sticks.
- rst asserted at payload beat 1 → next cycle all outputs 0, credits=CREDITS; the next packet starts at source 0.
- Header-only packets from 3 sources → hdr_vld high 3 consecutive cycles with datareq=0 and no src_beat_rd pulses.
